rsa_operand_loader: RTL



---
 rtl/rsa_pkg.sv | 27 ++
 rtl/rsa_operand_loader_if.sv | 11 +
 rtl/rsa_operand_loader.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared constants for the RSA operand loader: operand indices, header field
// positions and FSM state encoding.
package rsa_pkg;

   localparam int OP_R2    = 0;
   localparam int OP_N     = 1;
   localparam int OP_M     = 2;
   localparam int OP_PHI_N = 3;
   localparam int OP_EI    = 4;
   localparam int NUM_OPS  = 5;

   // Header word layout: op_id in the low bits, len starting at bit 16
   localparam int OP_ID_W     = 3;
   localparam int HDR_OP_LSB  = 0;
   localparam int HDR_LEN_LSB = 16;

   localparam logic [1:0] S_HDR  = 2'd0;
   localparam logic [1:0] S_DATA = 2'd1;
   localparam logic [1:0] S_SKIP = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   // Out-of-range ids shift the bit off the top and yield an all-zero mask
   function automatic logic [NUM_OPS-1:0] op_onehot(input logic [OP_ID_W-1:0] id);
      return NUM_OPS'(1) << id;
   endfunction

endpackage

// File: rtl/rsa_operand_loader_if.sv
// Host word stream (valid/ready) feeding the operand loader.
interface rsa_operand_loader_if #(
   parameter int WORD_W = 32
) ();
   logic [WORD_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;

   modport master (output s_data, output s_valid, input  s_ready);
   modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/rsa_operand_loader.sv
// Parses header+payload packets from the host and steers payload words into
// five operand FIFOs with a registered one-hot write strobe.
module rsa_operand_loader
   import rsa_pkg::*;
#(
   parameter int WORD_W    = 32,
   parameter int MAX_WORDS = 128,
   parameter int LEN_W     = 8
) (
   input  logic                     clka,
   input  logic                     rst,
   rsa_operand_loader_if.slave      host,
   input  logic                     clear,
   output logic [WORD_W-1:0]        fifo_din,
   output logic [NUM_OPS-1:0]       fifo_wr_en,
   output logic [NUM_OPS*LEN_W-1:0] op_len,
   output logic [NUM_OPS-1:0]       loaded_mask,
   output logic                     load_done,
   output logic                     err,
   output logic                     busy
);

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_WORDS);

   logic [1:0]         state;
   logic [1:0]         state_nxt;
   logic [OP_ID_W-1:0] op_q;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   rem_cnt;
   logic               ready;

   logic               accept;
   logic [OP_ID_W-1:0] hdr_op;
   logic [LEN_W-1:0]   hdr_len;
   logic               len_zero;
   logic               hdr_ok;
   logic               last_word;
   logic [NUM_OPS-1:0] new_mask;

   assign accept    = host.s_valid && ready;
   assign hdr_op    = host.s_data[HDR_OP_LSB +: OP_ID_W];
   assign hdr_len   = host.s_data[HDR_LEN_LSB +: LEN_W];
   assign len_zero  = (hdr_len == '0);
   // A duplicate is a header whose operand bit is already set in the mask
   assign hdr_ok    = (hdr_op < OP_ID_W'(NUM_OPS)) && !len_zero && (hdr_len <= MAX_LEN)
                      && ((loaded_mask & op_onehot(hdr_op)) == '0);
   assign last_word = (rem_cnt == len_q - 1'b1);
   assign new_mask  = loaded_mask | op_onehot(op_q);

   always_ff @(posedge clka or posedge rst) begin
      if (rst) state <= S_HDR;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = S_HDR;
      end else begin
         case (state)
            S_HDR: begin
               if (accept) begin
                  if (hdr_ok)        state_nxt = S_DATA;
                  else if (len_zero) state_nxt = S_HDR;
                  else               state_nxt = S_SKIP;
               end
            end
            S_DATA: begin
               if (accept && last_word)
                  state_nxt = (new_mask == '1) ? S_DONE : S_HDR;
            end
            S_SKIP: begin
               if (accept && last_word) state_nxt = S_HDR;
            end
            default: state_nxt = state;
         endcase
      end
   end

   always_comb begin
      ready = (state != S_DONE);
      busy  = (state != S_HDR);
   end

   assign host.s_ready = ready;
   assign load_done    = (loaded_mask == '1);

   // Write strobe, per-operand lengths and mask all update on the accept edge
   always_ff @(posedge clka or posedge rst) begin
      if (rst) begin
         fifo_din    <= '0;
         fifo_wr_en  <= '0;
         op_len      <= '0;
         loaded_mask <= '0;
         err         <= 1'b0;
         op_q        <= '0;
         len_q       <= '0;
         rem_cnt     <= '0;
      end else if (clear) begin
         fifo_wr_en  <= '0;
         op_len      <= '0;
         loaded_mask <= '0;
         err         <= 1'b0;
         op_q        <= '0;
         len_q       <= '0;
         rem_cnt     <= '0;
      end else begin
         fifo_wr_en <= '0;
         case (state)
            S_HDR: begin
               if (accept) begin
                  rem_cnt <= '0;
                  if (hdr_ok) begin
                     op_q  <= hdr_op;
                     len_q <= hdr_len;
                  end else begin
                     err <= 1'b1;
                     if (!len_zero) len_q <= hdr_len;
                  end
               end
            end
            S_DATA: begin
               if (accept) begin
                  fifo_wr_en <= op_onehot(op_q);
                  fifo_din   <= host.s_data;
                  rem_cnt    <= rem_cnt + 1'b1;
                  if (last_word) begin
                     op_len[int'(op_q)*LEN_W +: LEN_W] <= len_q;
                     loaded_mask                       <= new_mask;
                  end
               end
            end
            S_SKIP: begin
               if (accept) rem_cnt <= rem_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
